// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
//   Shared definitions for the bit-serial subtractor:
//   - FSM state encoding (plain 2-bit constants so older tools can use them)
//   - cnt_width(): width of the bit counter for a given operand width
package serial_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits are
    // enough. The floor of 1 keeps the vector legal for tiny widths.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/serial_sub_fa.sv
// serial_sub_fa
//   One-bit full adder cell. This is the single arithmetic element of the
//   serial subtractor.
//   Ports:
//     a_i, b_i  addend bits
//     ci_i      carry in
//     s_o       sum bit
//     co_o      carry out
module serial_sub_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_sub.sv
// serial_sub
//   Bit-serial WIDTH-bit subtractor, diff = a - b, LSB first, one bit per
//   clock. The subtraction is a + ~b + 1 through one full-adder cell, with
//   the carry flip-flop preset to 1 to supply the +1.
//   Ports:
//     clk         system clock, rising edge
//     reset       synchronous active-high reset
//     start       request, sampled only in IDLE
//     a, b        minuend / subtrahend, captured when start is accepted
//     busy        high while bits are being processed (RUN)
//     done        one-cycle pulse; results valid from this cycle on
//     diff        a - b modulo 2^WIDTH
//     borrow_out  unsigned borrow (a < b)
//     overflow    signed two's-complement overflow of a - b
//     zero        diff == 0
//   Results and flags hold until the next completion or a reset.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold last result
//   RUN   | one operand bit per cycle through the full adder
//   DONE  | results just updated, done pulse, back to IDLE
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow,
    output logic             zero
);

    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             carry_q,  carry_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q,    ovf_d;
    logic             zero_q,   zero_d;

    logic b_inv;
    logic fa_sum;
    logic fa_cout;

    assign b_inv = ~b_sr_q[0];

    serial_sub_fa u_fa (
        .a_i  (a_sr_q[0]),
        .b_i  (b_inv),
        .ci_i (carry_q),
        .s_o  (fa_sum),
        .co_o (fa_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so that after WIDTH shifts the
                // first (LSB) sum bit has arrived at bit 0.
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                if (cnt_q == CNT_LAST) begin
                    // Last bit: publish from the next-state value so the
                    // final sum bit is included. No carry out of a + ~b + 1
                    // means a borrow occurred.
                    state_d  = ST_DONE;
                    diff_d   = res_sr_d;
                    borrow_d = ~fa_cout;
                    ovf_d    = (a_msb_q != b_msb_q) && (fa_sum != a_msb_q);
                    zero_d   = (res_sr_d == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;
    assign zero       = zero_q;

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub
//   Self-checking bench for serial_sub: an 8-bit and a 2-bit instance,
//   checked against an arithmetic reference model (modular difference,
//   unsigned compare, signed range test).
module tb_serial_sub;

    logic       clk = 1'b0;
    logic       reset;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, bo8, ov8, z8;
    logic [7:0] diff8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2, bo2, ov2, z2;
    logic [1:0] diff2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_sub #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .a          (a8),
        .b          (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (bo8),
        .overflow   (ov8),
        .zero       (z8)
    );

    serial_sub #(.WIDTH(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start2),
        .a          (a2),
        .b          (b2),
        .busy       (busy2),
        .done       (done2),
        .diff       (diff2),
        .borrow_out (bo2),
        .overflow   (ov2),
        .zero       (z2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: results of a - b on w-bit operands, from plain arithmetic.
    function automatic void model(input int w, input longint ua, input longint ub,
                                  output logic [31:0] d, output logic bo,
                                  output logic ov, output logic z);
        longint m, dd, sa, sb, sd;
        m  = longint'(1) << w;
        dd = (ua - ub) % m;
        if (dd < 0) dd += m;
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        sd = sa - sb;
        d  = 32'(dd);
        bo = (ua < ub);
        ov = (sd >= m / 2) || (sd < -(m / 2));
        z  = (dd == 0);
    endfunction

    // One 8-bit operation starting at a negedge (cycle 0). With scramble set,
    // start stays high through RUN/DONE and the operands change every cycle.
    // Returns at the negedge of cycle 10, DUT back in IDLE.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input bit scramble);
        logic [31:0] ed, prev;
        logic        ebo, eov, ez;
        model(8, longint'(ta), longint'(tb), ed, ebo, eov, ez);
        prev   = 32'(diff8);
        start8 = 1'b1;
        a8     = ta;
        b8     = tb;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            chk("busy8", 32'(busy8), 32'(c <= 8));
            chk("done8", 32'(done8), 32'(c == 9));
            if (c <= 8) chk("diff8_hold", 32'(diff8), prev);
            if (c == 9) begin
                chk("diff8",   32'(diff8), ed);
                chk("borrow8", 32'(bo8),   32'(ebo));
                chk("ovf8",    32'(ov8),   32'(eov));
                chk("zero8",   32'(z8),    32'(ez));
            end
            if (scramble && c < 9) begin
                a8 = 8'($urandom);
                b8 = 8'($urandom);
            end else begin
                start8 = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] ed;
        logic        ebo, eov, ez;
        logic [7:0]  acc_a, acc_b;

        reset  = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy8", 32'(busy8), 0);
        chk("rst_done8", 32'(done8), 0);
        chk("rst_diff8", 32'(diff8), 0);
        chk("rst_flags8", {29'd0, bo8, ov8, z8}, 0);
        chk("rst_busy2", 32'(busy2), 0);
        reset = 1'b0;
        @(negedge clk);

        // directed cases
        op8(8'h05, 8'h03, 1'b0);
        op8(8'h03, 8'h05, 1'b0);
        op8(8'h80, 8'h01, 1'b0);
        op8(8'h5A, 8'h5A, 1'b0);
        op8(8'h00, 8'hFF, 1'b0);
        op8(8'h7F, 8'hFF, 1'b0);
        op8(8'hFF, 8'h00, 1'b0);

        // operands and start wiggled during RUN: original operands win
        op8(8'hC3, 8'h3C, 1'b1);
        op8(8'h10, 8'h90, 1'b1);

        // random operations
        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
        end

        // start held continuously: accepts every 10 cycles
        start8 = 1'b1;
        a8 = 8'($urandom); b8 = 8'($urandom);
        acc_a = a8; acc_b = b8;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            chk("hold_busy8", 32'(busy8), 32'((c % 10) >= 1 && (c % 10) <= 8));
            chk("hold_done8", 32'(done8), 32'((c % 10) == 9));
            if ((c % 10) == 9) begin
                model(8, longint'(acc_a), longint'(acc_b), ed, ebo, eov, ez);
                chk("hold_diff8", 32'(diff8), ed);
                chk("hold_bo8",   32'(bo8),   32'(ebo));
            end
            a8 = 8'($urandom); b8 = 8'($urandom);
            if ((c % 10) == 0) begin
                acc_a = a8; acc_b = b8;
            end
        end
        start8 = 1'b0;
        repeat (10) @(negedge clk);

        // make sure diff is nonzero, then abort mid-run with reset (and start)
        op8(8'h40, 8'h01, 1'b0);
        start8 = 1'b1; a8 = 8'h33; b8 = 8'h11;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            chk("pre_abort_busy8", 32'(busy8), 1);
        end
        reset  = 1'b1;
        start8 = 1'b1;
        @(negedge clk);
        chk("abort_busy8", 32'(busy8), 0);
        chk("abort_done8", 32'(done8), 0);
        chk("abort_diff8", 32'(diff8), 0);
        chk("abort_flags8", {29'd0, bo8, ov8, z8}, 0);
        reset  = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
        chk("idle_after_abort", 32'(busy8), 0);
        op8(8'h33, 8'h11, 1'b0);

        // WIDTH=2: all 16 operand pairs
        for (int i = 0; i < 16; i++) begin
            model(2, longint'(i / 4), longint'(i % 4), ed, ebo, eov, ez);
            start2 = 1'b1;
            a2 = 2'(i / 4);
            b2 = 2'(i % 4);
            for (int c = 1; c <= 4; c++) begin
                @(negedge clk);
                start2 = 1'b0;
                chk("busy2", 32'(busy2), 32'(c <= 2));
                chk("done2", 32'(done2), 32'(c == 3));
                if (c == 3) begin
                    chk("diff2",   32'(diff2), ed);
                    chk("borrow2", 32'(bo2),   32'(ebo));
                    chk("ovf2",    32'(ov2),   32'(eov));
                    chk("zero2",   32'(z2),    32'(ez));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Counterpart to the team's combinational full adder: it performs subtraction sequentially as a + ~b + 1 through a single full-adder cell and a carry flip-flop.
- Used in the lab datapath wherever a small, slow subtract is acceptable, e.g. PS/2 scan-code offset and VGA coordinate deltas.
- Start/done handshake; results held until the next operation.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; sampled in the cycle start is accepted.
- b  input  WIDTH  subtrahend; sampled in the cycle start is accepted.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; results valid from this cycle.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  unsigned borrow: 1 when a < b as unsigned.
- overflow  output  1  signed two's-complement overflow of a - b.
- zero  output  1  diff == 0.

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset).
- Reset:
  - state=IDLE.
  - busy=0, done=0, diff=0, borrow_out=0, overflow=0, zero=0.
  - Internal shift registers, counter and carry flip-flop are cleared.
- Reset asserted mid-operation aborts the operation; reset values appear the cycle after the edge.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If start=1, latch a into a_sr and b into b_sr.
  - Set carry=1 (the +1 of two's complement), cnt=0, and capture a_msb=a[WIDTH-1] and b_msb=b[WIDTH-1].
  - Go to RUN.
  - If start=0, stay in IDLE; outputs hold their last values.
- RUN, one cycle per bit:
  - Full-adder inputs are a_sr[0], ~b_sr[0] and carry.
  - The sum bit shifts into the MSB of the result register (right shift).
  - a_sr and b_sr shift right; carry takes the adder carry-out; cnt increments.
  - When cnt==WIDTH-1, this is the last bit: go to DONE and update diff, borrow_out, overflow and zero from the final values.
- Output flags at completion:
  - borrow_out = ~final carry.
  - overflow = (a_msb != b_msb) && (diff[WIDTH-1] != a_msb).
  - zero = (diff == 0).
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- busy=1 exactly while in RUN.
- Latency: start accepted in cycle 0 → busy high in cycles 1..WIDTH → done high in cycle WIDTH+1 → IDLE in cycle WIDTH+2.
  - Earliest next accept is cycle WIDTH+2, so the throughput is one operation per WIDTH+2 cycles.
- start while in RUN or DONE is ignored and not queued. Changes to a or b after acceptance have no effect.
- diff and the flags keep their old values during RUN. They change only on the edge entering DONE and then hold until the next completion or a reset.
- Counter width is clog2(WIDTH); it does not wrap within an operation.
- Simultaneous reset and start: reset wins.

Decomposition:
- Shared package:
  - FSM state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Function computing counter width from WIDTH.
- One sub-module: instantiate the team's existing FA (full adder) cell for the per-bit sum and carry. No other sub-modules.

Test Plan:
1. WIDTH=8, a=0x05, b=0x03, start pulse in cycle 0 → busy cycles 1..8, done only in cycle 9, diff=0x02, borrow_out=0, overflow=0, zero=0.
2. a=0x03, b=0x05 → diff=0xFE, borrow_out=1, overflow=0, zero=0. Then a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1.
3. a=0x5A, b=0x5A → diff=0x00, zero=1, borrow_out=0. Then a=0x00, b=0xFF → diff=0x01, borrow_out=1, overflow=0.
4. Operands changed and start held high during RUN → result reflects the originally latched operands, no second done. start held continuously → accepts at cycles 0, 10, 20 (period WIDTH+2).
5. reset asserted in cycle 4 of an operation → next cycle busy=0, done=0, diff=0, all flags 0, state IDLE; a fresh start completes normally.
6. WIDTH=2 build, exhaustive 16 operand pairs → diff, borrow_out and overflow match the reference model; done in cycle 3 after each start.
